pattern_tx: RTL and testbench
=============================

Name: pattern_tx

Overview:
Serial pattern transmitter. It is the driving end of the single-bit sequence interface that the team's sequence-detector FSMs (input x, output F/S) consume. A parallel pattern of up to WIDTH bits is loaded with a START strobe and shifted out MSB-first on x, one bit per clock, optionally repeated with idle gaps between repetitions. It replaces hand-written x stimulus in detector benches and serves as a synthesizable stream source.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of LEN; must hold WIDTH
REP_W, 4, width of REPEAT
GAP, 2, idle (x=0) cycles between repetitions; 0 allowed

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
START  in  1  request a transmission; sampled only in IDLE
ABORT  in  1  synchronous abort of the current transmission
DATA  in  WIDTH  pattern; bit LEN-1 sent first, bit 0 last
LEN  in  LEN_W  number of bits to send, legal range 1..WIDTH
REPEAT  in  REP_W  extra repetitions; total transmissions = REPEAT+1
x  out  1  serial output bit, registered
X_VALID  out  1  high while x carries a pattern bit
BUSY  out  1  high whenever S != IDLE
DONE  out  1  one-cycle pulse when a transmission completes normally
S  out  2  current state: IDLE=0, SEND=1, GAP=2, FIN=3

Behaviour:
- Reset (RESET_N low, asynchronous): x=0, X_VALID=0, BUSY=0, DONE=0, S=IDLE. All counters and the shift register clear. Takes effect immediately, including mid-transmission.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE: x=0, X_VALID=0.
  - On an edge with START=1, ABORT=0 and 1<=LEN<=WIDTH, the block captures DATA, LEN and REPEAT.
  - The bit counter loads LEN and the repetition counter loads REPEAT.
  - Next state is SEND, and x=DATA[LEN-1] in that same cycle (first bit one clock after the START edge).
- Illegal LEN (0 or >WIDTH): START is ignored. The block stays in IDLE and raises no DONE.
- SEND: X_VALID=1 and one bit per cycle in order DATA[LEN-1] down to DATA[0]. On the last bit:
  - repetition counter > 0 and GAP > 0: go to GAP and decrement the counter.
  - repetition counter > 0 and GAP = 0: restart SEND directly from the captured pattern (back-to-back, no idle bit) and decrement the counter.
  - repetition counter = 0: go to FIN.
- GAP: x=0, X_VALID=0 for exactly GAP cycles. Then SEND restarts from the captured pattern bit LEN-1.
- FIN: one cycle with x=0, X_VALID=0, DONE=1, BUSY=1. Next state is IDLE. START is not accepted in FIN.
- Busy cycle count per accepted START: (REPEAT+1)*LEN + REPEAT*GAP + 1.
- START while BUSY: ignored. DATA/LEN/REPEAT changes while BUSY have no effect because they were captured at load.
- ABORT=1 at an edge in SEND, GAP or FIN: next state is IDLE with x=0, X_VALID=0 and DONE=0 (an abort in FIN suppresses no further pulse because the pulse is already out). ABORT in IDLE blocks a same-cycle START.
- Counter widths are sized from LEN_W and REP_W. Counters do not wrap because decrements happen only when the value is nonzero.

Decomposition:
- Shared package pattern_pkg holds the state encoding constants (IDLE/SEND/GAP/FIN, 2-bit) and the default GAP. Detector benches import the same package.
- One sub-module, piso_shift: a WIDTH-bit parallel-load, MSB-relative (LEN-1) shift register with load/shift enables and asynchronous active-low clear.
- The FSM and the two counters stay in pattern_tx.

Test Plan:
1. WIDTH=8, GAP=2. DATA=8'b1011_0110, LEN=8, REPEAT=0, START for one cycle -> x=1,0,1,1,0,1,1,0 on 8 consecutive cycles with X_VALID=1, then DONE=1 for 1 cycle; BUSY high for 9 cycles; S sequence 1×8, 3, 0.
2. DATA=8'h05, LEN=3, REPEAT=2 -> x/X_VALID: 101(v), 00(gap, !v), 101(v), 00, 101(v), then DONE; 14 busy cycles. Rerun with GAP=0 -> 101101101 contiguous, DONE at cycle 10.
3. START with LEN=0, then with LEN=9 -> S stays 0, BUSY=0, DONE never asserted, x=0.
4. START again with DATA=8'hFF during scenario 1, cycle 3 -> ignored; output stream is unchanged from scenario 1.
5. ABORT in the 4th SEND cycle of scenario 1 -> next edge S=0, x=0, X_VALID=0, no DONE. START and ABORT together in IDLE -> not accepted.
6. RESET_N pulsed low for 5 ns mid-GAP in scenario 2 -> outputs reach reset values immediately, without waiting for CLK. A fresh START afterwards transmits correctly from bit LEN-1.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared encoding for the serial pattern source and the sequence detectors it feeds.
package pattern_pkg;

  // State encoding, visible on the S output
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Idle cycles inserted between repetitions unless overridden
  localparam int GAP_DEFAULT = 2;

endpackage

// File: rtl/pattern_tx_if.sv
// Control/stream bundle between a pattern_tx and whatever drives and consumes it.
interface pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
);
  logic             START;
  logic             ABORT;
  logic [WIDTH-1:0] DATA;
  logic [LEN_W-1:0] LEN;
  logic [REP_W-1:0] REPEAT;
  logic             x;
  logic             X_VALID;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       S;

  // Controller side: issues requests, observes the stream
  modport master (
    output START, ABORT, DATA, LEN, REPEAT,
    input  x, X_VALID, BUSY, DONE, S
  );

  // Transmitter side
  modport slave (
    input  START, ABORT, DATA, LEN, REPEAT,
    output x, X_VALID, BUSY, DONE, S
  );
endinterface

// File: rtl/pattern_tx_piso_shift.sv
// Parallel-in serial-out shifter. The pattern is left-aligned at load so that
// bit len-1 sits in the MSB; the serial output is then a plain flop bit and
// drains to zero once all len bits have been shifted out.
module piso_shift #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] aligned;

  // Move bit len-1 of the pattern into the MSB position
  always_comb begin
    aligned = din << (WIDTH - int'(len));
  end

  // Shift register: clear has priority over load, load over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (clr) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= aligned;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign dout = sreg[WIDTH-1];
endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends LEN bits of a captured pattern MSB-first,
// REPEAT extra times, with GAP idle cycles between repetitions.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  pattern_tx_if.slave bus
);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  logic [1:0]       state_reg, state_next;
  logic [LEN_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [LEN_W-1:0] len_reg;
  logic [WIDTH-1:0] data_reg;
  logic             x_valid_reg, x_valid_next;
  logic             done_reg, done_next;
  logic             busy_reg;
  logic             capture, load, shift, clr;
  logic             len_legal;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;

  assign len_legal = (bus.LEN != '0) && (int'(bus.LEN) <= WIDTH);
  assign load_data = capture ? bus.DATA : data_reg;
  assign load_len  = capture ? bus.LEN  : len_reg;

  // Next-state and datapath control
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rep_cnt_next = rep_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    x_valid_next = 1'b0;
    done_next    = 1'b0;
    capture      = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    clr          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.START && !bus.ABORT && len_legal) begin
          capture      = 1'b1;
          load         = 1'b1;
          bit_cnt_next = bus.LEN;
          rep_cnt_next = bus.REPEAT;
          x_valid_next = 1'b1;
          state_next   = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.ABORT) begin
          clr        = 1'b1;
          state_next = S_IDLE;
        end else if (bit_cnt_reg == LEN_W'(1)) begin
          if (rep_cnt_reg != '0) begin
            rep_cnt_next = rep_cnt_reg - REP_W'(1);
            if (GAP > 0) begin
              shift        = 1'b1;
              gap_cnt_next = GAP_W'(GAP);
              state_next   = S_GAP;
            end else begin
              // Back-to-back repetition: reload without an idle bit
              load         = 1'b1;
              bit_cnt_next = len_reg;
              x_valid_next = 1'b1;
            end
          end else begin
            shift      = 1'b1;
            done_next  = 1'b1;
            state_next = S_FIN;
          end
        end else begin
          shift        = 1'b1;
          bit_cnt_next = bit_cnt_reg - LEN_W'(1);
          x_valid_next = 1'b1;
        end
      end
      S_GAP: begin
        if (bus.ABORT) begin
          clr        = 1'b1;
          state_next = S_IDLE;
        end else if (gap_cnt_reg <= GAP_W'(1)) begin
          load         = 1'b1;
          bit_cnt_next = len_reg;
          x_valid_next = 1'b1;
          state_next   = S_SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      default: begin
        // FIN: DONE is already out this cycle, abort or not we return to IDLE
        clr        = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // State, counters, captured request and registered status outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      rep_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      len_reg     <= '0;
      data_reg    <= '0;
      x_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      rep_cnt_reg <= rep_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      x_valid_reg <= x_valid_next;
      done_reg    <= done_next;
      busy_reg    <= (state_next != S_IDLE);
      if (capture) begin
        len_reg  <= bus.LEN;
        data_reg <= bus.DATA;
      end
    end
  end

  piso_shift #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shift (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (clr),
    .load  (load),
    .shift (shift),
    .len   (load_len),
    .din   (load_data),
    .dout  (bus.x)
  );

  assign bus.X_VALID = x_valid_reg;
  assign bus.DONE    = done_reg;
  assign bus.BUSY    = busy_reg;
  assign bus.S       = state_reg;
endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: one DUT with GAP=2 and one with GAP=0,
// driven by identical stimulus.
module tb_pattern_tx;
  import pattern_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pattern_tx_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) bus ();
  pattern_tx_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) bus0 ();

  pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(2)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(0)) dut0 (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus0)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Observed status vector {x, X_VALID, BUSY, DONE, S}
  function automatic logic [5:0] obs_a();
    return {bus.x, bus.X_VALID, bus.BUSY, bus.DONE, bus.S};
  endfunction

  function automatic logic [5:0] obs_b();
    return {bus0.x, bus0.X_VALID, bus0.BUSY, bus0.DONE, bus0.S};
  endfunction

  // Behavioural expectation for cycle c after the accepting START edge
  function automatic logic [5:0] model(input logic [7:0] data, input int len,
                                       input int rep, input int gap, input int c);
    int per, span, pos;
    per  = len + gap;
    span = (rep + 1) * len + rep * gap;
    if (c < span) begin
      pos = c % per;
      if (pos < len) return {data[len-1-pos], 1'b1, 1'b1, 1'b0, S_SEND};
      return {1'b0, 1'b0, 1'b1, 1'b0, S_GAP};
    end
    if (c == span) return {1'b0, 1'b0, 1'b1, 1'b1, S_FIN};
    return 6'b0;
  endfunction

  task automatic drive(input logic start, input logic abort, input logic [7:0] data,
                       input logic [3:0] len, input logic [3:0] rep);
    bus.START  = start;  bus0.START  = start;
    bus.ABORT  = abort;  bus0.ABORT  = abort;
    bus.DATA   = data;   bus0.DATA   = data;
    bus.LEN    = len;    bus0.LEN    = len;
    bus.REPEAT = rep;    bus0.REPEAT = rep;
  endtask

  // One-cycle START pulse; returns at the negedge of the first cycle after it
  task automatic kick(input logic [7:0] data, input logic [3:0] len, input logic [3:0] rep);
    @(negedge CLK);
    drive(1'b1, 1'b0, data, len, rep);
    @(negedge CLK);
    bus.START = 1'b0;
    bus0.START = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 6'b0) begin
      errors++;
      $display("FAIL reset_a: got %b required %b", obs_a(), 6'b0);
    end
    checks++;
    if (obs_b() !== 6'b0) begin
      errors++;
      $display("FAIL reset_b: got %b required %b", obs_b(), 6'b0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs_a() !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: got %b required %b", obs_a(), 6'b0);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [5:0] e;
    kick(8'b1011_0110, 4'd8, 4'd0);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge CLK);
      e = model(8'b1011_0110, 8, 0, 2, c);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL single_a cycle %0d: got %b required %b", c, obs_a(), e);
      end
      checks++;
      if (obs_b() !== e) begin
        errors++;
        $display("FAIL single_b cycle %0d: got %b required %b", c, obs_b(), e);
      end
    end
    $display("test_single done");
  endtask

  task automatic test_busy_ignore();
    logic [5:0] e;
    kick(8'b1011_0110, 4'd8, 4'd0);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge CLK);
      e = model(8'b1011_0110, 8, 0, 2, c);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: got %b required %b", c, obs_a(), e);
      end
      if (c == 2) drive(1'b1, 1'b0, 8'hFF, 4'd8, 4'd3);
      if (c == 3) bus.START = 1'b0;
      if (c == 3) bus0.START = 1'b0;
    end
    drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
    $display("test_busy_ignore done");
  endtask

  task automatic test_repeat();
    logic [5:0] ea, eb;
    kick(8'h05, 4'd3, 4'd2);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge CLK);
      ea = model(8'h05, 3, 2, 2, c);
      eb = model(8'h05, 3, 2, 0, c);
      checks++;
      if (obs_a() !== ea) begin
        errors++;
        $display("FAIL repeat_gap2 cycle %0d: got %b required %b", c, obs_a(), ea);
      end
      checks++;
      if (obs_b() !== eb) begin
        errors++;
        $display("FAIL repeat_gap0 cycle %0d: got %b required %b", c, obs_b(), eb);
      end
    end
    $display("test_repeat done");
  endtask

  task automatic test_illegal_len();
    logic [3:0] lens [2];
    lens[0] = 4'd0;
    lens[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      kick(8'hFF, lens[k], 4'd0);
      for (int c = 0; c < 4; c++) begin
        if (c > 0) @(negedge CLK);
        checks++;
        if (obs_a() !== 6'b0) begin
          errors++;
          $display("FAIL illegal_len%0d cycle %0d: got %b required %b", lens[k], c, obs_a(), 6'b0);
        end
      end
    end
    $display("test_illegal_len done");
  endtask

  task automatic test_abort();
    logic [5:0] e;
    kick(8'b1011_0110, 4'd8, 4'd0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge CLK);
      e = model(8'b1011_0110, 8, 0, 2, c);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %b required %b", c, obs_a(), e);
      end
    end
    bus.ABORT = 1'b1;
    bus0.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    bus0.ABORT = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge CLK);
      checks++;
      if (obs_a() !== 6'b0 || obs_b() !== 6'b0) begin
        errors++;
        $display("FAIL abort_post cycle %0d: got %b/%b required %b", c, obs_a(), obs_b(), 6'b0);
      end
    end
    @(negedge CLK);
    drive(1'b1, 1'b1, 8'hAA, 4'd4, 4'd0);
    @(negedge CLK);
    drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge CLK);
      checks++;
      if (obs_a() !== 6'b0) begin
        errors++;
        $display("FAIL start_with_abort cycle %0d: got %b required %b", c, obs_a(), 6'b0);
      end
    end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid_gap();
    logic [5:0] e;
    kick(8'h05, 4'd3, 4'd2);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge CLK);
      e = model(8'h05, 3, 2, 2, c);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: got %b required %b", c, obs_a(), e);
      end
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 6'b0 || obs_b() !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b/%b required %b", obs_a(), obs_b(), 6'b0);
    end
    #4 RESET_N = 1'b1;
    kick(8'h13, 4'd5, 4'd0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge CLK);
      e = model(8'h13, 5, 0, 2, c);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL post_reset_a cycle %0d: got %b required %b", c, obs_a(), e);
      end
      checks++;
      if (obs_b() !== e) begin
        errors++;
        $display("FAIL post_reset_b cycle %0d: got %b required %b", c, obs_b(), e);
      end
    end
    $display("test_reset_mid_gap done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_ignore();
    test_repeat();
    test_illegal_len();
    test_abort();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
